// File: rtl/z16_fetch_stage.sv
// rtl/z16_fetch_stage.sv - Z16 instruction fetch stage with IF/ID register
//
// Purpose:
//   Drives the PC into a combinational instruction memory, captures the
//   returned instruction into the IF/ID register, and hands it to decode
//   with a valid/ready handshake. Supports PC redirects (flush of the
//   fetched slot) and a sticky halt that freezes fetch until reset.
//
// Optional feature:
//   Z16_FETCH_PERF_EN - when defined, adds o_fetch_count, a 32-bit count of
//   accepted handshakes (o_valid && i_ready). Not cleared by redirect/halt.
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_rst_n          asynchronous active-low reset
//   o_imem_addr      instruction memory byte address (= PC, bit 0 always 0)
//   i_imem_data      instruction returned combinationally for o_imem_addr
//   o_instr          IF/ID instruction register
//   o_pc             address from which o_instr was fetched
//   o_valid          o_instr/o_pc hold a live instruction
//   i_ready          decode accepts o_instr this cycle
//   i_redirect       redirect PC this cycle (taken BEQ, JRL)
//   i_redirect_addr  redirect target, bit 0 dropped
//   i_halt           stop request from decode
//   o_halted         sticky halt flag
//   o_fetch_count    accepted-fetch counter (Z16_FETCH_PERF_EN only)

module z16_fetch_stage #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_imem_addr,
    input  logic [15:0] i_imem_data,
    output logic [15:0] o_instr,
    output logic [15:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_addr,
    input  logic        i_halt,
    output logic        o_halted
`ifdef Z16_FETCH_PERF_EN
    ,
    output logic [31:0] o_fetch_count
`endif
);

    // Halfword alignment is enforced on the reset vector as well.
    localparam logic [15:0] LP_RESET_PC = {RESET_ADDR[15:1], 1'b0};

    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_fetch_pc;
    logic        r_valid;
    logic        r_halted;

    logic        w_load;
    logic        w_handshake;
    logic [15:0] w_redirect_pc;
    logic [15:0] w_pc_next;

    // Bit 0 of the redirect target is architecturally meaningless.
    logic        w_unused_ok;
    assign w_unused_ok = i_redirect_addr[0];

    always_comb begin
        w_load        = 1'b0;
        w_handshake   = 1'b0;
        w_redirect_pc = 16'h0000;
        w_pc_next     = 16'h0000;

        // A new instruction enters the IF/ID slot only when it is empty or
        // being drained this cycle, and nothing higher priority is pending.
        w_load        = !r_halted && !i_redirect && !i_halt && (!r_valid || i_ready);
        w_handshake   = r_valid && i_ready;
        w_redirect_pc = {i_redirect_addr[15:1], 1'b0};
        // Natural 16-bit wrap: 16'hFFFE + 2 -> 16'h0000.
        w_pc_next     = r_pc + 16'd2;
    end

    // Priority per edge: halt > redirect > load > hold. Once halted, nothing
    // changes until reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc       <= LP_RESET_PC;
            r_instr    <= 16'h0000;
            r_fetch_pc <= 16'h0000;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else if (!r_halted) begin
            if (i_halt) begin
                // Any instruction presented alongside the halt is either
                // consumed by decode (i_ready) or dropped; PC is frozen.
                r_halted <= 1'b1;
                r_valid  <= 1'b0;
            end else if (i_redirect) begin
                // Flush the slot; the target is fetched on the next edge,
                // giving exactly one bubble.
                r_pc    <= w_redirect_pc;
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_instr    <= i_imem_data;
                r_fetch_pc <= r_pc;
                r_valid    <= 1'b1;
                r_pc       <= w_pc_next;
            end
        end
    end

`ifdef Z16_FETCH_PERF_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_count <= 32'd0;
        end else if (w_handshake) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign o_fetch_count = r_fetch_count;
`endif

    assign o_imem_addr = r_pc;
    assign o_instr     = r_instr;
    assign o_pc        = r_fetch_pc;
    assign o_valid     = r_valid;
    assign o_halted    = r_halted;

endmodule

// File: tb/tb_z16_fetch_stage.sv
// tb/tb_z16_fetch_stage.sv - self-checking bench for z16_fetch_stage

module tb_z16_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        ready;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;
    logic        halted;
`ifdef Z16_FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    int n_cmp;
    int n_fail;

    logic [15:0] mem [0:1023];

    // Reference model: architectural state described by the fetch rules.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_opc;
    logic        m_valid;
    logic        m_halted;
    logic [31:0] m_count;

    z16_fetch_stage #(.RESET_ADDR(16'h0000)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .o_imem_addr     (imem_addr),
        .i_imem_data     (imem_data),
        .o_instr         (instr),
        .o_pc            (pc),
        .o_valid         (valid),
        .i_ready         (ready),
        .i_redirect      (redirect),
        .i_redirect_addr (redirect_addr),
        .i_halt          (halt),
        .o_halted        (halted)
`ifdef Z16_FETCH_PERF_EN
        ,
        .o_fetch_count   (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[10:1]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"}, {16'h0, imem_addr}, {16'h0, m_pc});
        chk({tag, ".valid"},     {31'h0, valid},     {31'h0, m_valid});
        chk({tag, ".halted"},    {31'h0, halted},    {31'h0, m_halted});
        if (m_valid) begin
            chk({tag, ".instr"}, {16'h0, instr}, {16'h0, m_instr});
            chk({tag, ".pc"},    {16'h0, pc},    {16'h0, m_opc});
        end
`ifdef Z16_FETCH_PERF_EN
        chk({tag, ".count"}, fetch_count, m_count);
`endif
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_instr  = 16'h0000;
        m_opc    = 16'h0000;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_count  = 32'd0;
    endtask

    // Called at a negedge: apply inputs, advance one rising edge in both
    // DUT and model, return at the next negedge and compare.
    task automatic step(input string tag, input logic rdy, input logic redir,
                        input logic [15:0] raddr, input logic hlt);
        ready         = rdy;
        redirect      = redir;
        redirect_addr = raddr;
        halt          = hlt;
        @(posedge clk);
        if (m_valid && rdy) m_count = m_count + 32'd1;
        if (m_halted) begin
            // frozen until reset
        end else if (hlt) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end else if (redir) begin
            m_pc    = raddr & 16'hFFFE;
            m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            m_instr = mem[m_pc[10:1]];
            m_opc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd2;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset.instr", {16'h0, instr}, 32'h0);
        chk("reset.pc",    {16'h0, pc},    32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        ready         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        halt          = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0010;
        mem[1] = 16'h0119;
        mem[2] = 16'h0040;

        @(negedge clk);
        do_reset();

        // Sequential fetch after reset release
        step("seq0", 1'b1, 1'b0, 16'h0, 1'b0);
        chk("seq0.instr_lit", {16'h0, instr}, 32'h0010);
        chk("seq0.addr_lit",  {16'h0, imem_addr}, 32'h0002);
        step("seq1", 1'b1, 1'b0, 16'h0, 1'b0);
        chk("seq1.instr_lit", {16'h0, instr}, 32'h0119);

        // Backpressure holds 0119 @ 2
        for (int i = 0; i < 3; i++) step("bp", 1'b0, 1'b0, 16'h0, 1'b0);
        chk("bp.pc_lit",   {16'h0, pc},        32'h0002);
        chk("bp.addr_lit", {16'h0, imem_addr}, 32'h0004);
        step("bp_rel", 1'b1, 1'b0, 16'h0, 1'b0);
        chk("bp_rel.pc_lit",    {16'h0, pc},    32'h0004);
        chk("bp_rel.instr_lit", {16'h0, instr}, 32'h0040);

        // Redirect to 0x0015 while o_pc = 0x001A
        step("to1a", 1'b1, 1'b1, 16'h001A, 1'b0);
        step("at1a", 1'b1, 1'b0, 16'h0, 1'b0);
        chk("at1a.pc_lit", {16'h0, pc}, 32'h001A);
        step("redir15", 1'b1, 1'b1, 16'h0015, 1'b0);
        chk("redir15.addr_lit", {16'h0, imem_addr}, 32'h0014);
        step("redir15b", 1'b1, 1'b0, 16'h0, 1'b0);
        chk("redir15b.pc_lit", {16'h0, pc}, 32'h0014);

        // Redirect with a stalled live instruction: discarded, not counted
        step("redir_stall", 1'b0, 1'b1, 16'h0100, 1'b0);
        step("redir_stall2", 1'b0, 1'b0, 16'h0, 1'b0);

        // Redirect while slot empty: no extra bubble
        step("redir_empty", 1'b1, 1'b1, 16'h0200, 1'b0);
        step("redir_empty2", 1'b1, 1'b1, 16'h0300, 1'b0);
        step("redir_empty3", 1'b1, 1'b0, 16'h0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) == 0), 16'($urandom), 1'b0);
        end

        // PC wrap at 16'hFFFE
        step("wrap0", 1'b1, 1'b1, 16'hFFFF, 1'b0);
        step("wrap1", 1'b1, 1'b0, 16'h0, 1'b0);
        chk("wrap1.addr_lit", {16'h0, imem_addr}, 32'h0000);
        chk("wrap1.pc_lit",   {16'h0, pc},        32'hFFFE);
        step("wrap2", 1'b1, 1'b0, 16'h0, 1'b0);

        // Halt together with redirect, then ignore everything
        step("halt", 1'b1, 1'b1, 16'h0400, 1'b1);
        chk("halt.flag_lit", {31'h0, halted}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            step("halted", 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
        end

        // Asynchronous reset mid-cycle clears halt
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset.halted", {31'h0, halted}, 32'h0);
        chk("areset.valid",  {31'h0, valid},  32'h0);
        chk("areset.addr",   {16'h0, imem_addr}, 32'h0);
        @(negedge clk);
        do_reset();

        // Five accepted fetches after a fresh reset
        for (int i = 0; i < 6; i++) step("five", 1'b1, 1'b0, 16'h0, 1'b0);
`ifdef Z16_FETCH_PERF_EN
        chk("five.count_lit", fetch_count, 32'd5);
`endif
        chk("five.pc_lit", {16'h0, pc}, 32'h000A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/z16_fetch_stage.md
Name: z16_fetch_stage

Overview:
- Instruction fetch stage of the Z16 CPU; sits between the program counter and decode.
- Drives a halfword-aligned address into the combinational instruction memory and captures the returned 16-bit instruction into the IF/ID register, with a valid/ready handshake towards decode.
- Accepts PC redirects (taken BEQ, JRL) from the execute/branch logic, flushing the fetched slot.
- Supports a sticky halt request that freezes fetch until reset.

Parameters:
- RESET_ADDR, 16'h0000, PC value loaded on reset; bit 0 is ignored (forced 0).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- o_imem_addr  output  16  instruction memory byte address; always equals the PC register; bit 0 always 0.
- i_imem_data  input  16  instruction word returned combinationally for o_imem_addr.
- o_instr  output  16  IF/ID instruction register.
- o_pc  output  16  address from which o_instr was fetched.
- o_valid  output  1  o_instr/o_pc hold a live instruction.
- i_ready  input  1  decode accepts o_instr this cycle.
- i_redirect  input  1  redirect PC this cycle.
- i_redirect_addr  input  16  redirect target; bit 0 is dropped.
- i_halt  input  1  stop request from decode (STOP instruction).
- o_halted  output  1  sticky halt flag.

Behaviour:
- Reset (async, i_rst_n=0): pc=RESET_ADDR&~1, o_instr=16'h0000, o_pc=16'h0000, o_valid=0, o_halted=0. Release is synchronous to the next edge; the first load occurs on the first rising edge with i_rst_n=1.
- load = !o_halted && !i_redirect && !i_halt && (!o_valid || i_ready).
- Priority per edge: halt > redirect > load > hold.
- Halt: i_halt=1 sets o_halted=1 and o_valid=0, and leaves pc unchanged; no further loads or redirects take effect until reset. An instruction presented in the same cycle is considered consumed if i_ready=1.
- Redirect (not halted): pc<={i_redirect_addr[15:1],1'b0}, o_valid=0 (flush). The instruction on o_instr in that cycle is consumed if i_ready=1; otherwise it is discarded.
- Load: o_instr<=i_imem_data, o_pc<=pc, o_valid<=1, pc<=pc+2 mod 2^16 (16'hFFFE wraps to 16'h0000).
- Hold (o_valid=1 and i_ready=0): o_instr, o_pc and pc are stable. o_imem_addr keeps pointing at the next address.
- Latency:
  - Reset release to first o_valid: 1 edge.
  - Redirect asserted in cycle N: cycle N+1 has o_valid=0 and o_imem_addr=target. Cycle N+2 has o_valid=1 with the target instruction. This is a one-cycle bubble.
- Throughput: one instruction per cycle while i_ready=1.
- i_redirect while o_valid=0 is legal: same result, no extra bubble.
- Mid-operation reset: all state is cleared immediately, including o_halted.

Optional Feature:
- Macro Z16_FETCH_PERF_EN.
- Defined: adds output port o_fetch_count (32-bit), reset 0. It increments by 1 on every edge where o_valid && i_ready, wrapping at 2^32. It is not cleared by redirect or halt.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, i_ready=1, imem returns 16'h0010/16'h0119/16'h0040 at 0/2/4 -> o_instr sequence 0010, 0119, 0040 on consecutive cycles; o_pc 0, 2, 4; o_imem_addr 2, 4, 6.
- Backpressure: i_ready=0 for 3 cycles while o_instr=16'h0119, o_pc=2 -> outputs and o_imem_addr=4 stable. i_ready=1 -> next o_pc=4, no instruction lost or duplicated.
- Redirect to 16'h0015 at o_pc=16'h001A with i_ready=1 -> next cycle o_valid=0, o_imem_addr=16'h0014; following cycle o_valid=1, o_pc=16'h0014.
- Redirect with i_ready=0 and o_valid=1 -> held instruction discarded; o_valid=0 next cycle; no handshake counted (perf count unchanged when Z16_FETCH_PERF_EN is defined).
- i_halt=1 together with i_redirect=1 -> o_halted=1, o_valid=0, pc unchanged. Later redirects and i_ready are ignored until i_rst_n=0, which clears o_halted asynchronously.
- PC at 16'hFFFE loads -> next o_imem_addr=16'h0000. With Z16_FETCH_PERF_EN defined, 5 accepted fetches -> o_fetch_count=5.
